spi_reg_bridge: RTL and testbench

SPI slave front-end that decodes serial command frames into single-cycle accesses on the internal register bus (i_wen/i_ren/i_addr/i_wdata/o_rdata) that every register slice in the chip listens to. It is the initiator side of that bus: it drives write and read strobes, address and write data, and returns read data (the OR of all slice o_rdata) serially on MISO. All SPI pins are oversampled in the i_clk domain; there is no SCLK clock domain. Framing errors are flagged as a single-cycle pulse, intended to drive i_lgc_wen of a W1C status register.

---
 rtl/pwr_spi_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 24 ++
 rtl/spi_reg_bridge.sv | 140 ++++++++++++++
 tb/tb_spi_reg_bridge.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pwr_spi_pkg.sv
// rtl/pwr_spi_pkg.sv - shared types and frame geometry for the SPI register bridge
package pwr_spi_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, RD_REQ, DATA} state_e;

  localparam logic CMD_WR = 1'b1;

  function automatic int frm_len(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  function automatic int addr_end(input int aw);
    return 1 + aw;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 2-flop synchronizer plus edge flop for one SPI pin
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= {3{RST_VAL}};
    else          sync_q <= {sync_q[1:0], pin_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI slave decoding serial frames into register bus accesses
module spi_reg_bridge
  import pwr_spi_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spi_sclk,
  input  logic          i_spi_csb,
  input  logic          i_spi_mosi,
  output logic          o_spi_miso,
  output logic          o_spi_miso_oe,
  output logic          o_wen,
  output logic          o_ren,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic          o_frm_err
);

  localparam int FRM_LEN = frm_len(AW, DW);
  localparam int CW      = $clog2(FRM_LEN + 1);
  localparam int SW      = max2(addr_end(AW), DW);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRM_LEN);
  localparam logic [CW-1:0] CNT_AEND = CW'(addr_end(AW));

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csb_lvl, csb_rise, csb_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .pin_i(i_spi_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_csb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .pin_i(i_spi_csb),
    .level_o(csb_lvl), .rise_o(csb_rise), .fall_o(csb_fall));
  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .pin_i(i_spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [1:0]    settle_q, settle_d;
  logic is_wr_q, is_wr_d, miso_q, miso_d, err_q, err_d;
  logic wen_q, wen_d, ferr_q, ferr_d, arm_q, arm_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;     cnt_q   <= '0;   sh_q    <= '0;
      addr_q   <= '0;       wdata_q <= '0;   dout_q  <= '0;
      settle_q <= '0;       is_wr_q <= 1'b0; miso_q  <= 1'b0;
      err_q    <= 1'b0;     wen_q   <= 1'b0; ferr_q  <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;  cnt_q   <= cnt_d;   sh_q    <= sh_d;
      addr_q   <= addr_d;   wdata_q <= wdata_d; dout_q  <= dout_d;
      settle_q <= settle_d; is_wr_q <= is_wr_d; miso_q  <= miso_d;
      err_q    <= err_d;    wen_q   <= wen_d;   ferr_q  <= ferr_d;
      arm_q    <= arm_d;
    end
  end

  // A CSB already low when reset releases must go high before a frame may start.
  assign settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
  assign arm_d    = arm_q | ((settle_q == 2'd2) & csb_lvl);

  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;   sh_d   = sh_q;
    addr_d  = addr_q;   wdata_d = wdata_q; dout_d = dout_q;
    is_wr_d = is_wr_q;  miso_d  = miso_q;  err_d  = err_q;
    wen_d   = 1'b0;     ferr_d  = 1'b0;
    if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (csb_fall && arm_q) begin
        state_d = ADDR;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    end else if (csb_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      if (err_q || cnt_q != CNT_FULL) begin
        ferr_d = 1'b1;
      end else if (is_wr_q) begin
        wen_d   = 1'b1;
        wdata_d = sh_q[DW-1:0];
      end
    end else begin
      if (sclk_rise) begin
        if (cnt_q == CNT_FULL) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          sh_d  = {sh_q[SW-2:0], mosi_lvl};
        end
      end
      case (state_q)
        ADDR: begin
          miso_d = 1'b0;
          if (cnt_q == CNT_AEND) begin
            is_wr_d = (sh_q[AW] == CMD_WR);
            addr_d  = sh_q[AW-1:0];
            state_d = is_wr_d ? DATA : RD_REQ;
          end
        end
        RD_REQ: begin
          miso_d  = i_rdata[DW-1];
          dout_d  = {i_rdata[DW-2:0], 1'b0};
          state_d = DATA;
        end
        DATA: begin
          // The fall that ends the last address bit arrives after RD_REQ; skip it.
          if (!is_wr_q && sclk_fall && cnt_q > CNT_AEND) begin
            miso_d = dout_q[DW-1];
            dout_d = {dout_q[DW-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ren         = (state_q == RD_REQ);
  assign o_wen         = wen_q;
  assign o_addr        = addr_q;
  assign o_wdata       = wdata_q;
  assign o_frm_err     = ferr_q;
  assign o_spi_miso    = miso_q;
  assign o_spi_miso_oe = ~csb_lvl;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;

  localparam int HP = 8;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, csb = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, wen, ren, ferr;
  logic [6:0] addr;
  logic [7:0] wdata, rdata, rd_val;
  logic [7:0] rx;

  int n_cmp = 0, n_bad = 0;
  int wen_cnt = 0, ren_cnt = 0, err_cnt = 0;
  bit exp_wr_frame = 1'b0;
  logic [6:0] exp_addr = '0;
  logic [7:0] exp_data = '0;

  always #5 clk = ~clk;

  assign rdata = ren ? rd_val : 8'h00;

  spi_reg_bridge #(.AW(7), .DW(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spi_sclk(sclk), .i_spi_csb(csb), .i_spi_mosi(mosi),
    .o_spi_miso(miso), .o_spi_miso_oe(miso_oe),
    .o_wen(wen), .o_ren(ren), .o_addr(addr), .o_wdata(wdata),
    .i_rdata(rdata), .o_frm_err(ferr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wen) begin
        wen_cnt++;
        check("wen_addr", 32'(addr), 32'(exp_addr));
        check("wen_data", 32'(wdata), 32'(exp_data));
      end
      if (ren) begin
        ren_cnt++;
        check("ren_addr", 32'(addr), 32'(exp_addr));
      end
      if (ferr) err_cnt++;
      if (wen || ren) check("strobe_exclusive", 32'(wen & ren), 0);
      if (exp_wr_frame && miso) check("miso_write_frame", 32'(miso), 0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input bit wr, input logic [6:0] a, input logic [7:0] d,
                           input int nbits, input int gap);
    logic [15:0] w;
    bit full;
    w = {wr, a, d};
    full = (nbits == 16);
    rx = '0;
    exp_wr_frame = wr; exp_addr = a; exp_data = d;
    wen_cnt = 0; ren_cnt = 0; err_cnt = 0;
    csb = 1'b0;
    wait_clk(HP);
    check("miso_oe_active", 32'(miso_oe), 1);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'b0;
      wait_clk(HP);
      if (i == 4) check("miso_addr_phase", 32'(miso), 0);
      if (i == 8) check("ren_before_data", ren_cnt, wr ? 0 : 1);
      if (i >= 8 && i < 16) rx = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
    end
    wait_clk(HP);
    csb = 1'b1;
    wait_clk(gap);
    check("wen_count", wen_cnt, (wr && full) ? 1 : 0);
    check("ren_count", ren_cnt, (!wr && nbits >= 8) ? 1 : 0);
    check("frm_err_count", err_cnt, full ? 0 : 1);
    check("miso_oe_idle", 32'(miso_oe), 0);
  endtask

  initial begin
    rd_val = 8'h00;
    wait_clk(3);
    check("reset_outputs", {wen, ren, addr, wdata, miso, miso_oe, ferr}, 0);
    rst_n = 1'b1;
    wait_clk(10);

    run_frame(1'b1, 7'h15, 8'hA5, 16, 20);
    check("write_addr_literal", 32'(addr), 32'h15);
    check("write_data_literal", 32'(wdata), 32'hA5);

    rd_val = 8'h3C;
    run_frame(1'b0, 7'h15, 8'h00, 16, 20);
    check("read_miso_literal", 32'(rx), 32'h3C);

    run_frame(1'b1, 7'h33, 8'h77, 12, 20);
    check("short_no_commit", 32'(wdata), 32'hA5);
    run_frame(1'b1, 7'h33, 8'h77, 16, 20);
    check("after_short_data", 32'(wdata), 32'h77);

    run_frame(1'b1, 7'h10, 8'hFF, 17, 20);
    check("overlen_no_commit", 32'(wdata), 32'h77);

    run_frame(1'b1, 7'h01, 8'h5A, 16, 6);
    rd_val = 8'hC3;
    run_frame(1'b0, 7'h01, 8'h00, 16, 6);
    check("b2b_read_miso", 32'(rx), 32'hC3);
    check("b2b_write_held", 32'(wdata), 32'h5A);

    rd_val = 8'h81;
    run_frame(1'b0, 7'h7F, 8'h00, 17, 20);
    check("overlen_read_miso", 32'(rx), 32'h81);

    exp_wr_frame = 1'b1; exp_addr = 7'h44; exp_data = 8'h99;
    wen_cnt = 0; ren_cnt = 0; err_cnt = 0;
    csb = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < 11; i++) begin
      mosi = (i == 0) ? 1'b1 : i[0];
      wait_clk(HP);
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
    end
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(3);
    check("midframe_reset_outputs", {wen, ren, addr, wdata, miso, miso_oe, ferr}, 0);
    rst_n = 1'b1;
    wait_clk(10);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
      wait_clk(HP);
    end
    csb = 1'b1;
    wait_clk(20);
    check("reset_no_strobes", wen_cnt + ren_cnt + err_cnt, 0);
    check("reset_addr_zero", 32'(addr), 0);

    run_frame(1'b1, 7'h2A, 8'h5C, 16, 20);
    check("post_reset_addr", 32'(addr), 32'h2A);
    check("post_reset_data", 32'(wdata), 32'h5C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
